// File: rtl/delay_eq_checker.sv
// delay_eq_checker: compares each accepted sample with the one accepted eff_depth samples earlier.
// Define DEQ_MASK_EN to add a cmp_mask input that excludes bits from the compare.
module delay_eq_checker #(
    parameter int WIDTH     = 8,
    parameter int MAX_DEPTH = 8,
    parameter int DW        = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
`ifdef DEQ_MASK_EN
    input  logic [WIDTH-1:0] cmp_mask,
`endif
    input  logic [DW-1:0]    depth,
    input  logic             clear,
    output logic             out_valid,
    output logic             out_eq,
    output logic [WIDTH-1:0] out_delayed,
    output logic [CNT_W-1:0] match_cnt,
    output logic             mismatch_sticky
);
    localparam int AW = MAX_DEPTH > 1 ? $clog2(MAX_DEPTH) : 1;

    logic [WIDTH-1:0] hist_q [MAX_DEPTH];
    logic [WIDTH-1:0] hist_d [MAX_DEPTH];
    logic [DW-1:0]    fill_q, fill_d, eff_depth;
    logic [AW-1:0]    ref_idx;
    logic [WIDTH-1:0] ref_data;
    logic             eq, cmp_ok;
    logic             out_valid_q, out_valid_d, out_eq_q, out_eq_d, sticky_q, sticky_d;
    logic [WIDTH-1:0] out_delayed_q, out_delayed_d;
    logic [CNT_W-1:0] match_q, match_d;

    assign eff_depth = depth == '0 ? DW'(1) : depth > DW'(MAX_DEPTH) ? DW'(MAX_DEPTH) : depth;
    assign ref_idx   = AW'(eff_depth - 1'b1);
    assign ref_data  = hist_q[ref_idx];
    assign cmp_ok    = fill_q >= eff_depth;
`ifdef DEQ_MASK_EN
    assign eq = ((in_data ^ ref_data) & ~cmp_mask) == '0;
`else
    assign eq = in_data == ref_data;
`endif

    // clear wins over in_valid: the sample presented with clear is dropped
    always_comb begin
        hist_d        = hist_q;
        fill_d        = fill_q;
        out_valid_d   = 1'b0;
        out_eq_d      = out_eq_q;
        out_delayed_d = out_delayed_q;
        match_d       = match_q;
        sticky_d      = sticky_q;
        if (clear) begin
            fill_d   = '0;
            match_d  = '0;
            sticky_d = 1'b0;
        end else if (in_valid) begin
            hist_d[0] = in_data;
            for (int k = 1; k < MAX_DEPTH; k++) hist_d[k] = hist_q[k-1];
            fill_d        = fill_q == DW'(MAX_DEPTH) ? fill_q : fill_q + 1'b1;
            out_valid_d   = cmp_ok;
            out_eq_d      = eq;
            out_delayed_d = ref_data;
            if (cmp_ok) begin
                match_d  = (eq && match_q != '1) ? match_q + 1'b1 : match_q;
                sticky_d = sticky_q | ~eq;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q        <= '{default: '0};
            fill_q        <= '0;
            out_valid_q   <= 1'b0;
            out_eq_q      <= 1'b0;
            out_delayed_q <= '0;
            match_q       <= '0;
            sticky_q      <= 1'b0;
        end else begin
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            out_valid_q   <= out_valid_d;
            out_eq_q      <= out_eq_d;
            out_delayed_q <= out_delayed_d;
            match_q       <= match_d;
            sticky_q      <= sticky_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_eq          = out_eq_q;
    assign out_delayed     = out_delayed_q;
    assign match_cnt       = match_q;
    assign mismatch_sticky = sticky_q;
endmodule

// File: tb/tb_delay_eq_checker.sv
// tb_delay_eq_checker: directed-vector bench for delay_eq_checker (default and CNT_W=2 instances).
module tb_delay_eq_checker;
    logic        clk = 1'b0;
    logic        rst, in_valid, clear;
    logic [7:0]  in_data, cmp_mask;
    logic [3:0]  depth;
    logic        out_valid, out_eq, sticky;
    logic [7:0]  out_delayed;
    logic [15:0] match_cnt;
    logic        s_out_valid, s_out_eq, s_sticky;
    logic [7:0]  s_out_delayed;
    logic [1:0]  s_match_cnt;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    delay_eq_checker u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef DEQ_MASK_EN
        .cmp_mask(cmp_mask),
`endif
        .depth(depth), .clear(clear), .out_valid(out_valid), .out_eq(out_eq),
        .out_delayed(out_delayed), .match_cnt(match_cnt), .mismatch_sticky(sticky)
    );

    delay_eq_checker #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef DEQ_MASK_EN
        .cmp_mask(cmp_mask),
`endif
        .depth(depth), .clear(clear), .out_valid(s_out_valid), .out_eq(s_out_eq),
        .out_delayed(s_out_delayed), .match_cnt(s_match_cnt), .mismatch_sticky(s_sticky)
    );

    task automatic drive(input logic v, input logic [7:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        drive(1'b0, 8'h00);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        depth = 4'd1;
        repeat (3) drive(1'b1, 8'h5A);
        vectors++;
        if (out_valid !== 1'b1 || match_cnt !== 16'd2) begin
            miscompares++;
            $display("FAIL pre_reset: out_valid=%b match_cnt=%0d, want 1 and 2", out_valid, match_cnt);
        end
        #3 rst = 1'b1;
        #1;
        vectors++;
        if ({out_valid, out_eq, out_delayed, match_cnt, sticky} !== 26'd0) begin
            miscompares++;
            $display("FAIL async_reset: v=%b eq=%b dly=%h cnt=%0d st=%b, want all 0",
                     out_valid, out_eq, out_delayed, match_cnt, sticky);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({out_valid, out_eq, out_delayed, match_cnt, sticky} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_hold: v=%b eq=%b dly=%h cnt=%0d st=%b, want all 0",
                     out_valid, out_eq, out_delayed, match_cnt, sticky);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_delay2();
        logic [7:0] d  [5] = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h33};
        logic       ev [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       eeq[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [7:0] edl[5] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h11};
        depth = 4'd2;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, d[i]);
            vectors++;
            if (out_valid !== ev[i] || (ev[i] && (out_eq !== eeq[i] || out_delayed !== edl[i]))) begin
                miscompares++;
                $display("FAIL delay2[%0d]: v=%b eq=%b dly=%h, want v=%b eq=%b dly=%h",
                         i, out_valid, out_eq, out_delayed, ev[i], eeq[i], edl[i]);
            end
        end
        vectors++;
        if (match_cnt !== 16'd2 || sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL delay2_stats: cnt=%0d st=%b, want 2 and 1", match_cnt, sticky);
        end
    endtask

    task automatic test_gaps();
        logic       v  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] d  [7] = '{8'hA5, 8'hFF, 8'h3C, 8'hFF, 8'h0F, 8'hA5, 8'h3C};
        logic       ev [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] edl[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h3C};
        do_clear();
        depth = 4'd3;
        for (int i = 0; i < 7; i++) begin
            drive(v[i], d[i]);
            vectors++;
            if (out_valid !== ev[i] || (ev[i] && (out_eq !== 1'b1 || out_delayed !== edl[i]))) begin
                miscompares++;
                $display("FAIL gaps[%0d]: v=%b eq=%b dly=%h, want v=%b eq=1 dly=%h",
                         i, out_valid, out_eq, out_delayed, ev[i], edl[i]);
            end
        end
        vectors++;
        if (match_cnt !== 16'd2 || sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL gaps_stats: cnt=%0d st=%b, want 2 and 0", match_cnt, sticky);
        end
    endtask

    task automatic test_depth_clamp();
        do_clear();
        depth = 4'd0;
        drive(1'b1, 8'h10);
        drive(1'b1, 8'h10);
        vectors++;
        if (out_valid !== 1'b1 || out_eq !== 1'b1 || out_delayed !== 8'h10) begin
            miscompares++;
            $display("FAIL depth0_eq: v=%b eq=%b dly=%h, want 1 1 10", out_valid, out_eq, out_delayed);
        end
        drive(1'b1, 8'h20);
        vectors++;
        if (out_valid !== 1'b1 || out_eq !== 1'b0 || out_delayed !== 8'h10) begin
            miscompares++;
            $display("FAIL depth0_ne: v=%b eq=%b dly=%h, want 1 0 10", out_valid, out_eq, out_delayed);
        end
        do_clear();
        depth = 4'd15;
        for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i));
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL depth15_fill: out_valid=%b, want 0", out_valid);
        end
        drive(1'b1, 8'h01);
        vectors++;
        if (out_valid !== 1'b1 || out_eq !== 1'b1 || out_delayed !== 8'h01) begin
            miscompares++;
            $display("FAIL depth15_eq: v=%b eq=%b dly=%h, want 1 1 01", out_valid, out_eq, out_delayed);
        end
        drive(1'b1, 8'h55);
        vectors++;
        if (out_valid !== 1'b1 || out_eq !== 1'b0 || out_delayed !== 8'h02) begin
            miscompares++;
            $display("FAIL depth15_ne: v=%b eq=%b dly=%h, want 1 0 02", out_valid, out_eq, out_delayed);
        end
    endtask

    task automatic test_saturate_clear();
        logic [1:0] ecnt[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_clear();
        depth = 4'd1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h77);
            vectors++;
            if (s_match_cnt !== ecnt[i]) begin
                miscompares++;
                $display("FAIL sat_cnt[%0d]: match_cnt=%0d, want %0d", i, s_match_cnt, ecnt[i]);
            end
        end
        drive(1'b1, 8'h78);
        drive(1'b1, 8'h77);
        vectors++;
        if (s_match_cnt !== 2'd3 || s_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_sticky: cnt=%0d st=%b, want 3 and 1", s_match_cnt, s_sticky);
        end
        clear = 1'b1;
        drive(1'b1, 8'h99);
        clear = 1'b0;
        vectors++;
        if (s_match_cnt !== 2'd0 || s_sticky !== 1'b0 || s_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clear: cnt=%0d st=%b v=%b, want 0 0 0", s_match_cnt, s_sticky, s_out_valid);
        end
        drive(1'b1, 8'h77);
        vectors++;
        if (s_out_valid !== 1'b0 || s_out_delayed !== 8'h77 || s_out_eq !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_drop: v=%b dly=%h eq=%b, want 0 77 1", s_out_valid, s_out_delayed, s_out_eq);
        end
        drive(1'b1, 8'h77);
        vectors++;
        if (s_out_valid !== 1'b1 || s_match_cnt !== 2'd1) begin
            miscompares++;
            $display("FAIL clear_refill: v=%b cnt=%0d, want 1 and 1", s_out_valid, s_match_cnt);
        end
    endtask

`ifdef DEQ_MASK_EN
    task automatic test_mask();
        do_clear();
        depth    = 4'd1;
        cmp_mask = 8'h0F;
        drive(1'b1, 8'hA1);
        drive(1'b1, 8'hA7);
        vectors++;
        if (out_valid !== 1'b1 || out_eq !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_eq: v=%b eq=%b, want 1 1", out_valid, out_eq);
        end
        drive(1'b1, 8'hB7);
        vectors++;
        if (out_eq !== 1'b0) begin
            miscompares++;
            $display("FAIL mask_ne: eq=%b, want 0", out_eq);
        end
        cmp_mask = 8'hFF;
        drive(1'b1, 8'h00);
        vectors++;
        if (out_eq !== 1'b1) begin
            miscompares++;
            $display("FAIL mask_all: eq=%b, want 1", out_eq);
        end
        cmp_mask = 8'h00;
    endtask
`endif

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        clear    = 1'b0;
        depth    = 4'd1;
        cmp_mask = 8'h00;
        test_reset();
        test_delay2();
        test_gaps();
        test_depth_clamp();
        test_saturate_clear();
`ifdef DEQ_MASK_EN
        test_mask();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
